// File: rtl/multicycle_adder_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_adder_if
// Description : Operand/result handshake bundle for multicycle_adder.
//               The master supplies operands and consumes results; the slave
//               is the adder itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_adder.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_adder
// Description : WIDTH-bit add/subtract computed DIGIT bits per clock by a
//               single DIGIT-wide ripple chain reused over NCHUNK cycles.
//               One operation in flight; result held until consumed.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4   // WIDTH must be a multiple of DIGIT
) (
  input  logic              clk,
  input  logic              rst,
  multicycle_adder_if.slave bus_io
);

  localparam int NCHUNK = WIDTH / DIGIT;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0] C_LAST = CW'(NCHUNK - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;       // already inverted for subtract
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             w_in_ready;
  int               w_lsb;
  logic [DIGIT-1:0] w_a;
  logic [DIGIT-1:0] w_b;
  logic [DIGIT-1:0] w_s;
  logic [DIGIT:0]   w_c;

  // Idle and out of reset: ready to take a new operation
  assign w_in_ready = (state_q == S_IDLE) && !rst;

  // Select the operand chunk addressed by the chunk counter
  assign w_lsb = int'(cnt_q) * DIGIT;
  assign w_a   = a_q[w_lsb +: DIGIT];
  assign w_b   = b_q[w_lsb +: DIGIT];
  assign w_c[0] = carry_q;

  // Ripple chain of DIGIT full-adder cells shared by every chunk
  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign w_s[i]   = w_a[i] ^ w_b[i] ^ w_c[i];
    assign w_c[i+1] = (w_a[i] & w_b[i]) | (w_c[i] & (w_a[i] ^ w_b[i]));
  end

  // Next-state logic for the IDLE -> RUN -> DONE sequencer and datapath
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (bus_io.in_valid && w_in_ready) begin
          // Subtract is a + ~b + ~cin: invert b and the borrow once here
          a_d     = bus_io.a;
          b_d     = bus_io.b ^ {WIDTH{bus_io.sub}};
          carry_d = bus_io.cin ^ bus_io.sub;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d[w_lsb +: DIGIT] = w_s;
        carry_d               = w_c[DIGIT];
        cnt_d                 = cnt_q + 1'b1;
        if (cnt_q == C_LAST) begin
          cout_d  = w_c[DIGIT];
          ovf_d   = w_c[DIGIT] ^ w_c[DIGIT-1];
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus_io.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset discards any in-flight operation
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus_io.in_ready  = w_in_ready;
  assign bus_io.out_valid = (state_q == S_DONE);
  assign bus_io.sum       = sum_q;
  assign bus_io.cout      = cout_q;
  assign bus_io.ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_adder
// Description : Directed vector bench for multicycle_adder in three builds
//               (DIGIT = 4, 16, 1) sharing one clock, reset and operand bus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  ivld = 3'b000;
  logic [2:0]  ordy = 3'b000;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic        op_cin = 1'b0;
  logic        op_sub = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  multicycle_adder_if #(.WIDTH(16)) if0 ();
  multicycle_adder_if #(.WIDTH(16)) if1 ();
  multicycle_adder_if #(.WIDTH(16)) if2 ();

  multicycle_adder #(.WIDTH(16), .DIGIT(4))  u_d4  (.clk(clk), .rst(rst), .bus_io(if0));
  multicycle_adder #(.WIDTH(16), .DIGIT(16)) u_d16 (.clk(clk), .rst(rst), .bus_io(if1));
  multicycle_adder #(.WIDTH(16), .DIGIT(1))  u_d1  (.clk(clk), .rst(rst), .bus_io(if2));

  assign if0.in_valid = ivld[0];  assign if0.out_ready = ordy[0];
  assign if1.in_valid = ivld[1];  assign if1.out_ready = ordy[1];
  assign if2.in_valid = ivld[2];  assign if2.out_ready = ordy[2];
  assign if0.a = op_a; assign if0.b = op_b; assign if0.cin = op_cin; assign if0.sub = op_sub;
  assign if1.a = op_a; assign if1.b = op_b; assign if1.cin = op_cin; assign if1.sub = op_sub;
  assign if2.a = op_a; assign if2.b = op_b; assign if2.cin = op_cin; assign if2.sub = op_sub;

  wire        o_ir [3];
  wire        o_ov [3];
  wire [15:0] o_sum[3];
  wire        o_co [3];
  wire        o_of [3];
  assign o_ir[0] = if0.in_ready; assign o_ov[0] = if0.out_valid; assign o_sum[0] = if0.sum;
  assign o_co[0] = if0.cout;     assign o_of[0] = if0.ovf;
  assign o_ir[1] = if1.in_ready; assign o_ov[1] = if1.out_valid; assign o_sum[1] = if1.sum;
  assign o_co[1] = if1.cout;     assign o_of[1] = if1.ovf;
  assign o_ir[2] = if2.in_ready; assign o_ov[2] = if2.out_valid; assign o_sum[2] = if2.sum;
  assign o_co[2] = if2.cout;     assign o_of[2] = if2.ovf;

  typedef struct {
    int          d;      // which build: 0 = DIGIT 4, 1 = DIGIT 16, 2 = DIGIT 1
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] es;
    logic        ec;
    logic        eo;
    int          el;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one operation on build d, scramble the bus after the accept edge,
  // wait for the result, consume it. Caller is at #1 after a rising edge.
  task automatic run_op(input int d, input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic tc, input logic ts,
                        output logic [15:0] rs, output logic rc, output logic ro,
                        output int lat);
    chk($sformatf("accept_ready[%0d]", d), {31'd0, o_ir[d]}, 32'd1);
    op_a = ta; op_b = tb_v; op_cin = tc; op_sub = ts;
    ivld[d] = 1'b1;
    @(posedge clk); #1;
    ivld[d] = 1'b0;
    op_a = 16'hDEAD; op_b = 16'hBEEF; op_cin = ~tc; op_sub = ~ts;
    lat = 0;
    while (!o_ov[d] && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!o_ov[d]) begin
      fails++; tests++;
      $display("FAIL timeout[%0d]: out_valid never rose, got 0 expected 1", d);
    end
    rs = o_sum[d]; rc = o_co[d]; ro = o_of[d];
    ordy[d] = 1'b1;
    @(posedge clk); #1;
    ordy[d] = 1'b0;
  endtask

  initial begin
    logic [15:0] rs;
    logic        rc, ro;
    int          lat;

    vecs[0]  = '{0, 16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 4};
    vecs[1]  = '{0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4};
    vecs[2]  = '{0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 4};
    vecs[3]  = '{0, 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 4};
    vecs[4]  = '{0, 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 4};
    vecs[5]  = '{0, 16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0, 4};
    vecs[6]  = '{0, 16'h00FF, 16'h0F01, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0, 4};
    vecs[7]  = '{0, 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 4};
    vecs[8]  = '{0, 16'hAAAA, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 4};
    vecs[9]  = '{1, 16'hAAAA, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1};
    vecs[10] = '{2, 16'hAAAA, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, o_ir[0]}, 32'd0);
    chk("rst_out_valid", {31'd0, o_ov[0]}, 32'd0);
    chk("rst_sum", {16'd0, o_sum[0]}, 32'd0);
    chk("rst_cout_ovf", {30'd0, o_co[0], o_of[0]}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", {29'd0, o_ir[2], o_ir[1], o_ir[0]}, 32'd7);
    @(posedge clk); #1;

    // Vector table
    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].d, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, rs, rc, ro, lat);
      chk($sformatf("v%0d_sum", i), {16'd0, rs}, {16'd0, vecs[i].es});
      chk($sformatf("v%0d_cout", i), {31'd0, rc}, {31'd0, vecs[i].ec});
      chk($sformatf("v%0d_ovf", i), {31'd0, ro}, {31'd0, vecs[i].eo});
      chk($sformatf("v%0d_lat", i), lat, vecs[i].el);
      chk($sformatf("v%0d_idle", i), {31'd0, o_ir[vecs[i].d]}, 32'd1);
    end

    // Backpressure in DONE with ignored in_valid pulses
    op_a = 16'h1234; op_b = 16'h0FFF; op_cin = 1'b0; op_sub = 1'b0;
    ivld[0] = 1'b1;
    @(posedge clk); #1;
    ivld[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("bp_valid", {31'd0, o_ov[0]}, 32'd1);
    for (int c = 0; c < 5; c++) begin
      op_a = 16'h7FFF; op_b = 16'h0001;
      ivld[0] = c[0];
      @(posedge clk); #1;
      chk($sformatf("bp%0d_sum", c), {16'd0, o_sum[0]}, 32'h2233);
      chk($sformatf("bp%0d_flags", c), {29'd0, o_ov[0], o_co[0], o_of[0]}, 32'd4);
      chk($sformatf("bp%0d_in_ready", c), {31'd0, o_ir[0]}, 32'd0);
    end
    ivld[0] = 1'b0;
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    ordy[0] = 1'b0;
    chk("bp_release", {30'd0, o_ov[0], o_ir[0]}, 32'd1);
    repeat (6) @(posedge clk);
    #1;
    chk("bp_not_queued", {31'd0, o_ov[0]}, 32'd0);

    // Reset in RUN at chunk 2
    op_a = 16'hFFFF; op_b = 16'hFFFF; op_cin = 1'b1; op_sub = 1'b0;
    ivld[0] = 1'b1;
    @(posedge clk); #1;
    ivld[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_valid", {31'd0, o_ov[0]}, 32'd0);
    chk("mid_rst_outs", {14'd0, o_sum[0], o_co[0], o_of[0]}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, o_ir[0]}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", {31'd0, o_ir[0]}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_no_result", {31'd0, o_ov[0]}, 32'd0);
    run_op(0, 16'h0001, 16'h0001, 1'b0, 1'b0, rs, rc, ro, lat);
    chk("post_rst_sum", {16'd0, rs}, 32'h0002);
    chk("post_rst_flags", {30'd0, rc, ro}, 32'd0);
    chk("post_rst_lat", lat, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time got 200000 expected less");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
